// File: rtl/odd_even_sort_engine_pkg.sv
// Shared definitions for the odd-even transposition sort engine:
// default element width, FSM state encoding and a constant clog2 helper.
package odd_even_sort_engine_pkg;

    // Default element width (pixel depth) used when W is not overridden.
    localparam int BIT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions such as port widths.
    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/odd_even_sort_engine_cmp_swap_cell.sv
// W-bit compare-exchange cell. 'lo' is the value destined for the lower
// index and 'hi' for the higher index, so in descending mode 'lo' carries
// the larger value. Equal values never swap.
module odd_even_sort_engine_cmp_swap_cell
    import odd_even_sort_engine_pkg::*;
#(
    parameter int W = BIT_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swapped
);

    assign swapped = desc ? (a < b) : (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/odd_even_sort_engine.sv
// Iterative odd-even transposition sorter for an N-element window.
// One phase per clock; even phases exchange pairs (0,1),(2,3)..., odd
// phases exchange (1,2),(3,4)... Optional early exit after two
// consecutive swap-free phases. Results are registered in DONE.
module odd_even_sort_engine
    import odd_even_sort_engine_pkg::*;
#(
    parameter int N          = 9,
    parameter int W          = BIT_WIDTH,
    parameter int EARLY_EXIT = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       desc_i,
    input  logic [N*W-1:0]             in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [N*W-1:0]             out_data_o,
    output logic [W-1:0]               median_o,
    output logic [W-1:0]               min_o,
    output logic [W-1:0]               max_o,
    output logic [ceil_log2(N+1)-1:0]  phase_count_o,
    output logic                       busy_o
);

    localparam int CW = ceil_log2(N + 1);

    state_t           state;
    logic [N*W-1:0]   arr;
    logic             desc_q;
    logic [CW-1:0]    phase_cnt;
    logic             prev_clean;

    logic [W-1:0]     cell_lo   [N-1];
    logic [W-1:0]     cell_hi   [N-1];
    logic [N-2:0]     cell_swap;

    logic [N*W-1:0]   next_arr;
    logic             any_swap;
    logic [CW-1:0]    next_cnt;
    logic             finish_sort;
    logic [W-1:0]     first_elem;
    logic [W-1:0]     last_elem;

    // One compare-exchange cell per adjacent pair; phase parity picks the active half.
    for (genvar k = 0; k < N - 1; k++) begin : g_cell
        odd_even_sort_engine_cmp_swap_cell #(.W(W)) u_cell (
            .a       (arr[k*W +: W]),
            .b       (arr[(k+1)*W +: W]),
            .desc    (desc_q),
            .lo      (cell_lo[k]),
            .hi      (cell_hi[k]),
            .swapped (cell_swap[k])
        );
    end

    // Build the array after the current phase and decide whether sorting ends here.
    always_comb begin
        next_arr = arr;
        any_swap = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if ((k % 2 == 1) == phase_cnt[0]) begin
                next_arr[k*W +: W]     = cell_lo[k];
                next_arr[(k+1)*W +: W] = cell_hi[k];
                any_swap               = any_swap | cell_swap[k];
            end
        end
        next_cnt    = phase_cnt + 1'b1;
        finish_sort = (next_cnt == CW'(N)) ||
                      ((EARLY_EXIT != 0) && (next_cnt >= CW'(2)) && !any_swap && prev_clean);
        first_elem  = next_arr[0 +: W];
        last_elem   = next_arr[(N-1)*W +: W];
    end

    // Control FSM with registered handshake flags and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            arr           <= '0;
            desc_q        <= 1'b0;
            phase_cnt     <= '0;
            prev_clean    <= 1'b0;
            in_ready_o    <= 1'b1;
            out_valid_o   <= 1'b0;
            busy_o        <= 1'b0;
            out_data_o    <= '0;
            median_o      <= '0;
            min_o         <= '0;
            max_o         <= '0;
            phase_count_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        arr        <= in_data_i;
                        desc_q     <= desc_i;
                        phase_cnt  <= '0;
                        prev_clean <= 1'b0;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= SORT;
                    end
                end
                SORT: begin
                    arr        <= next_arr;
                    phase_cnt  <= next_cnt;
                    prev_clean <= !any_swap;
                    if (finish_sort) begin
                        state         <= DONE;
                        out_valid_o   <= 1'b1;
                        out_data_o    <= next_arr;
                        median_o      <= next_arr[(N/2)*W +: W];
                        min_o         <= desc_q ? last_elem : first_elem;
                        max_o         <= desc_q ? first_elem : last_elem;
                        phase_count_o <= next_cnt;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_even_sort_engine.sv
// Testbench for odd_even_sort_engine. Three instances: N=9 without early
// exit (0), N=9 with early exit (1), N=5 with early exit (2).
module tb_odd_even_sort_engine;

    localparam int W = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid  [3];
    logic        desc      [3];
    logic        out_ready [3];
    logic [71:0] in_data   [3];

    logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, busy0, busy1, busy2;
    logic [71:0] od0, od1;
    logic [39:0] od2;
    logic [7:0]  med0, med1, med2, mn0, mn1, mn2, mx0, mx1, mx2;
    logic [3:0]  pc0, pc1;
    logic [2:0]  pc2;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        rdy;
        logic        vld;
        logic        busy;
        logic [71:0] data;
        logic [7:0]  med;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [3:0]  pc;
    } snap_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic        desc;
        logic [71:0] din;
        logic [71:0] dout;
        logic [7:0]  med;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [3:0]  phases;
    } vec_t;

    always #5 CLK = ~CLK;

    odd_even_sort_engine #(.N(9), .W(W), .EARLY_EXIT(0)) dut0 (
        .CLK(CLK), .RST(RST), .in_valid_i(in_valid[0]), .in_ready_o(rdy0),
        .desc_i(desc[0]), .in_data_i(in_data[0]), .out_valid_o(vld0),
        .out_ready_i(out_ready[0]), .out_data_o(od0), .median_o(med0),
        .min_o(mn0), .max_o(mx0), .phase_count_o(pc0), .busy_o(busy0)
    );

    odd_even_sort_engine #(.N(9), .W(W), .EARLY_EXIT(1)) dut1 (
        .CLK(CLK), .RST(RST), .in_valid_i(in_valid[1]), .in_ready_o(rdy1),
        .desc_i(desc[1]), .in_data_i(in_data[1]), .out_valid_o(vld1),
        .out_ready_i(out_ready[1]), .out_data_o(od1), .median_o(med1),
        .min_o(mn1), .max_o(mx1), .phase_count_o(pc1), .busy_o(busy1)
    );

    odd_even_sort_engine #(.N(5), .W(W), .EARLY_EXIT(1)) dut2 (
        .CLK(CLK), .RST(RST), .in_valid_i(in_valid[2]), .in_ready_o(rdy2),
        .desc_i(desc[2]), .in_data_i(in_data[2][39:0]), .out_valid_o(vld2),
        .out_ready_i(out_ready[2]), .out_data_o(od2), .median_o(med2),
        .min_o(mn2), .max_o(mx2), .phase_count_o(pc2), .busy_o(busy2)
    );

    // Gather one instance's outputs into a single record.
    function automatic snap_t snap(input int s);
        snap_t r;
        r = '0;
        case (s)
            0: begin
                r.rdy = rdy0; r.vld = vld0; r.busy = busy0; r.data = od0;
                r.med = med0; r.mn = mn0; r.mx = mx0; r.pc = pc0;
            end
            1: begin
                r.rdy = rdy1; r.vld = vld1; r.busy = busy1; r.data = od1;
                r.med = med1; r.mn = mn1; r.mx = mx1; r.pc = pc1;
            end
            default: begin
                r.rdy = rdy2; r.vld = vld2; r.busy = busy2; r.data = {32'd0, od2};
                r.med = med2; r.mn = mn2; r.mx = mx2; r.pc = {1'b0, pc2};
            end
        endcase
        return r;
    endfunction

    function automatic logic [71:0] pk9(input int v[9]);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = v[i][7:0];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: apply the transposition phases on a plain array, stopping
    // after N phases or after two consecutive swap-free phases when enabled.
    task automatic modelSort(input int n, input bit ee, input bit d, input logic [71:0] data,
                             output logic [71:0] exp, output int phases,
                             output logic [7:0] med, output logic [7:0] mn, output logic [7:0] mx);
        int a[9];
        int t, sw, clean_run;
        exp = '0;
        mn  = 8'hFF;
        mx  = 8'h00;
        for (int i = 0; i < n; i++) begin
            a[i] = int'(data[i*8 +: 8]);
            if (data[i*8 +: 8] < mn) mn = data[i*8 +: 8];
            if (data[i*8 +: 8] > mx) mx = data[i*8 +: 8];
        end
        phases    = 0;
        clean_run = 0;
        while (phases < n) begin
            sw = 0;
            for (int i = phases % 2; i + 1 < n; i += 2) begin
                if (d ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    sw++;
                end
            end
            phases++;
            clean_run = (sw == 0) ? clean_run + 1 : 0;
            if (ee && clean_run >= 2) break;
        end
        for (int i = 0; i < n; i++) exp[i*8 +: 8] = a[i][7:0];
        med = a[n/2][7:0];
    endtask

    // Offer a job, wait for the capture edge, then count edges until out_valid.
    task automatic applyStimulus(input int s, input bit d, input logic [71:0] data,
                                 output snap_t res, output int lat);
        snap_t r;
        int waited;
        in_data[s]  = data;
        desc[s]     = d;
        in_valid[s] = 1'b1;
        waited = 0;
        r = snap(s);
        while (!r.rdy && waited < 50) begin
            @(posedge CLK); #1;
            waited++;
            r = snap(s);
        end
        if (waited >= 50) checkOutput("in_ready_timeout", 72'(r.rdy), 72'(1));
        @(posedge CLK); #1;
        in_valid[s] = 1'b0;
        lat = 0;
        r = snap(s);
        while (!r.vld && lat < 200) begin
            @(posedge CLK); #1;
            lat++;
            r = snap(s);
        end
        res = r;
    endtask

    // Accept the result and confirm the engine returns to IDLE right after.
    task automatic releaseOutput(input int s);
        snap_t r;
        out_ready[s] = 1'b1;
        @(posedge CLK); #1;
        out_ready[s] = 1'b0;
        r = snap(s);
        checkOutput("valid_drop", 72'(r.vld), 72'(0));
        checkOutput("ready_return", 72'(r.rdy), 72'(1));
        checkOutput("busy_drop", 72'(r.busy), 72'(0));
    endtask

    task automatic checkResult(input string tag, input snap_t r, input int lat,
                               input logic [71:0] exp, input int ph,
                               input logic [7:0] med, input logic [7:0] mn, input logic [7:0] mx);
        checkOutput({tag, "_data"}, r.data, exp);
        checkOutput({tag, "_median"}, 72'(r.med), 72'(med));
        checkOutput({tag, "_min"}, 72'(r.mn), 72'(mn));
        checkOutput({tag, "_max"}, 72'(r.mx), 72'(mx));
        checkOutput({tag, "_phases"}, 72'(r.pc), 72'(ph));
        checkOutput({tag, "_latency"}, 72'(lat), 72'(ph));
    endtask

    vec_t vecs[5];

    initial begin
        int t[9];
        snap_t r, held;
        int lat, ph, n;
        logic [71:0] exp, data;
        logic [7:0] med, mn, mx;
        bit d;

        for (int s = 0; s < 3; s++) begin
            in_valid[s] = 1'b0; desc[s] = 1'b0; out_ready[s] = 1'b0; in_data[s] = '0;
        end

        // Directed vectors taken from the behavioural description.
        t = '{9, 3, 7, 1, 4, 6, 8, 2, 5};
        vecs[0].sel = 2'd0; vecs[0].desc = 1'b0; vecs[0].din = pk9(t);
        t = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        vecs[0].dout = pk9(t); vecs[0].med = 8'd5; vecs[0].mn = 8'd1; vecs[0].mx = 8'd9; vecs[0].phases = 4'd9;
        vecs[1].sel = 2'd1; vecs[1].desc = 1'b0; vecs[1].din = pk9(t);
        vecs[1].dout = pk9(t); vecs[1].med = 8'd5; vecs[1].mn = 8'd1; vecs[1].mx = 8'd9; vecs[1].phases = 4'd2;
        t = '{9, 3, 7, 1, 4, 6, 8, 2, 5};
        vecs[2].sel = 2'd0; vecs[2].desc = 1'b1; vecs[2].din = pk9(t);
        t = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        vecs[2].dout = pk9(t); vecs[2].med = 8'd5; vecs[2].mn = 8'd1; vecs[2].mx = 8'd9; vecs[2].phases = 4'd9;
        t = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        vecs[3].sel = 2'd1; vecs[3].desc = 1'b0; vecs[3].din = pk9(t);
        vecs[3].dout = pk9(t); vecs[3].med = 8'd7; vecs[3].mn = 8'd7; vecs[3].mx = 8'd7; vecs[3].phases = 4'd2;
        t = '{1, 2, 3, 4, 5, 0, 0, 0, 0};
        vecs[4].sel = 2'd2; vecs[4].desc = 1'b1; vecs[4].din = pk9(t);
        t = '{5, 4, 3, 2, 1, 0, 0, 0, 0};
        vecs[4].dout = pk9(t); vecs[4].med = 8'd3; vecs[4].mn = 8'd1; vecs[4].mx = 8'd5; vecs[4].phases = 4'd5;

        // Reset state.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        r = snap(0);
        checkOutput("reset_ready", 72'(r.rdy), 72'(1));
        checkOutput("reset_valid", 72'(r.vld), 72'(0));
        checkOutput("reset_busy", 72'(r.busy), 72'(0));
        checkOutput("reset_data", r.data, 72'(0));
        checkOutput("reset_phases", 72'(r.pc), 72'(0));
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Table-driven directed jobs.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(int'(vecs[v].sel), vecs[v].desc, vecs[v].din, r, lat);
            checkResult($sformatf("vec%0d", v), r, lat, vecs[v].dout, int'(vecs[v].phases),
                        vecs[v].med, vecs[v].mn, vecs[v].mx);
            releaseOutput(int'(vecs[v].sel));
        end

        // Back-pressure: result held five cycles while a competing job is offered.
        t = '{4, 9, 1, 8, 2, 7, 3, 6, 5};
        applyStimulus(1, 1'b0, pk9(t), held, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid[1] = 1'b1;
            in_data[1]  = 72'(c + 1) * 72'h010101010101010101;
            @(posedge CLK); #1;
            r = snap(1);
            checkOutput("bp_data_stable", r.data, held.data);
            checkOutput("bp_valid_held", 72'(r.vld), 72'(1));
            checkOutput("bp_ready_low", 72'(r.rdy), 72'(0));
        end
        in_valid[1] = 1'b0;
        t = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        checkOutput("bp_result", held.data, pk9(t));
        releaseOutput(1);
        r = snap(1);
        checkOutput("bp_data_kept", r.data, pk9(t));

        // Reset asserted while the engine is in SORT phase 4.
        t = '{9, 3, 7, 1, 4, 6, 8, 2, 5};
        in_data[0] = pk9(t); desc[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge CLK); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        r = snap(0);
        checkOutput("pre_reset_busy", 72'(r.busy), 72'(1));
        RST = 1'b1;
        #1;
        r = snap(0);
        checkOutput("midsort_reset_valid", 72'(r.vld), 72'(0));
        checkOutput("midsort_reset_busy", 72'(r.busy), 72'(0));
        checkOutput("midsort_reset_data", r.data, 72'(0));
        checkOutput("midsort_reset_median", 72'(r.med), 72'(0));
        checkOutput("midsort_reset_phases", 72'(r.pc), 72'(0));
        checkOutput("midsort_reset_ready", 72'(r.rdy), 72'(1));
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        t = '{5, 4, 3, 2, 1, 0, 0, 0, 0};
        data = pk9(t);
        modelSort(5, 1'b1, 1'b0, data, exp, ph, med, mn, mx);
        applyStimulus(2, 1'b0, data, r, lat);
        checkResult("post_reset", r, lat, exp, ph, med, mn, mx);
        checkOutput("post_reset_median3", 72'(r.med), 72'(3));
        releaseOutput(2);

        // Randomized jobs against the reference model.
        for (int k = 0; k < 60; k++) begin
            int s;
            s = k % 3;
            n = (s == 2) ? 5 : 9;
            d = 1'($urandom_range(0, 1));
            data = '0;
            case ($urandom_range(0, 3))
                0: for (int i = 0; i < n; i++) data[i*8 +: 8] = 8'($urandom_range(0, 3));
                1: for (int i = 0; i < n; i++) data[i*8 +: 8] = 8'(i * 20 + $urandom_range(0, 19));
                default: for (int i = 0; i < n; i++) data[i*8 +: 8] = 8'($urandom);
            endcase
            modelSort(n, s != 0, d, data, exp, ph, med, mn, mx);
            applyStimulus(s, d, data, r, lat);
            checkResult($sformatf("rand%0d", k), r, lat, exp, ph, med, mn, mx);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
            releaseOutput(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
